score_display: RTL and testbench
================================

Name: score_display

Overview:
- Consumes the 10-bit game score produced by the score counter and drives the board's seven-segment displays.
- Converts the binary score to packed BCD with a sequential double-dabble engine, one shift per clock.
- Republishes the BCD digits and active-low HEX segment patterns whenever the score changes.
- Sits between the score counter and the top-level HEX pins; also exposes BCD for the screen/text renderer.

Parameters:
- SCORE_W, 10, width of the binary score input; also the number of shift iterations.
- NUM_DIGITS, 4, number of BCD digits/HEX displays; must satisfy 10^NUM_DIGITS > 2^SCORE_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- score  input  SCORE_W  binary score from the counter
- bcd  output  4*NUM_DIGITS  packed BCD of the last converted score; digit 0 = bits [3:0]
- hex  output  NUM_DIGITS*7  active-low segment patterns {g..a}; display i = bits [7i+6:7i]
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd/hex update

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: state=IDLE, shown=0, bcd=0, busy=0, done=0, all hex digits = "0" (7'b1000000).
- Reset mid-conversion aborts the conversion and discards partial results.
- IDLE state:
  - If score != shown: snap<=score, work<=0, cnt<=0, busy<=1, go to CONV.
  - Otherwise stay in IDLE with busy=0.
- CONV state, one iteration per clock:
  - For each BCD nibble of work that is >= 5, add 3 (all nibbles in parallel, combinationally).
  - Then shift {work,snap} left by 1.
  - cnt increments each iteration; after the SCORE_W-th shift (cnt==SCORE_W-1), go to DONE.
- DONE state, one cycle:
  - bcd<=work, shown<=snap, hex<=seg(work), done<=1, busy<=0, go to IDLE.
  - done is high for exactly one cycle, the cycle after bcd/hex update.
- Latency: a new score present at rising edge N is visible on bcd/hex after edge N+SCORE_W+1 (12 edges total for the default).
- Score changes during CONV/DONE are ignored. The next IDLE cycle compares against shown and restarts if they differ; the last stable value is always displayed eventually.
- Arithmetic:
  - work is 4*NUM_DIGITS bits; the add-3 never overflows a nibble.
  - Maximum input 1023 yields BCD 16'h1023.
  - Carry out of the top digit cannot occur under the parameter constraint.
- Segment map, active-low {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10-15 (unreachable) = 1111111.
- No combinational path from score to any output; all outputs are registered.

Optional Feature:
- Macro: SCORE_DISPLAY_BLANK_EN
- Defined: leading-zero blanking. In DONE, any display whose digit and all higher digits are 0 drives 7'b1111111; digit 0 is never blanked.
  - Reset hex = digit0 "0", others blank.
  - 7 shows as three blank displays then "7"; 1003 shows all four digits.
  - bcd output is unaffected.
- Undefined: all NUM_DIGITS displays always show their digit, including leading zeros.

Test Plan:
- Reset then hold score=0 for 20 cycles -> bcd=16'h0000, hex all 7'b1000000, busy stays 0, no done pulse.
- score 0->7 at edge N -> busy high from edge N+1, done pulse in cycle after edge N+11, bcd=16'h0007, hex0=7'b1111000.
- score=1023 -> bcd=16'h1023, hex3=1111001, hex2=1000000, hex1=0100100, hex0=0110000.
- score 5->6->7 on consecutive cycles during CONV -> the first conversion completes with 16'h0005, then a second conversion produces 16'h0007; no intermediate 6 is displayed.
- Assert rst 4 cycles into a conversion of 999 -> next cycle state=IDLE, bcd=0, busy=0, done never pulses for 999.
- With SCORE_DISPLAY_BLANK_EN, score=40 -> bcd=16'h0040, hex3=hex2=7'b1111111, hex1=0011001, hex0=1000000. Without the macro -> hex3=hex2=7'b1000000.

Source files
------------

// File: rtl/score_display.sv
// Binary score to BCD (sequential double-dabble, one shift per clock) and seven-segment driver.
// Optional leading-zero blanking when SCORE_DISPLAY_BLANK_EN is defined.
module score_display #(
    parameter int SCORE_W    = 10,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SCORE_W-1:0]      score,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS*7-1:0] hex,
    output logic                    busy,
    output logic                    done
);

    // state | meaning
    // IDLE  | waiting for score to differ from the displayed value
    // CONV  | one add-3/shift iteration per clock, SCORE_W iterations
    // DONE  | publish bcd/hex, pulse done

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state;
    logic [SCORE_W-1:0] shown;
    logic [SCORE_W-1:0] snap;
    logic [SCORE_W-1:0] target;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   work_adj;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        r = w;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [NUM_DIGITS*7-1:0] hex_of(input logic [BCD_W-1:0] w);
        logic [NUM_DIGITS*7-1:0] h;
        logic                    lead;
        h    = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w[4*i +: 4] != 4'd0)
                lead = 1'b0;
`ifdef SCORE_DISPLAY_BLANK_EN
            h[7*i +: 7] = (lead && i != 0) ? 7'b1111111 : seg7(w[4*i +: 4]);
`else
            h[7*i +: 7] = seg7(w[4*i +: 4]);
`endif
        end
        return h;
    endfunction

    always_comb begin
        work_adj = add3(work);
    end

    // snap is consumed by the shifter, so target keeps the score being converted for shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shown  <= '0;
            snap   <= '0;
            target <= '0;
            work   <= '0;
            cnt    <= '0;
            bcd    <= '0;
            hex    <= hex_of({BCD_W{1'b0}});
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (score != shown) begin
                        snap   <= score;
                        target <= score;
                        work   <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CONV: begin
                    {work, snap} <= {work_adj, snap} << 1;
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_W'(SCORE_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= work;
                    shown <= target;
                    hex   <= hex_of(work);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: vector table, corner sequences and randomized
// conversions compared against an arithmetic decimal/segment model.
module tb_score_display;

    localparam int SCORE_W    = 10;
    localparam int NUM_DIGITS = 4;
    localparam int LAT        = SCORE_W + 2;

    logic                    clk;
    logic                    rst;
    logic [SCORE_W-1:0]      score;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS*7-1:0] hex;
    logic                    busy;
    logic                    done;

    int checks;
    int errors;

    score_display #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .bcd   (bcd),
        .hex   (hex),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          value;
        logic [15:0] exp_bcd;
    } vec_t;

    logic [6:0] seg_tab [10];

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [27:0] model_hex(input int v);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[7*i +: 7] = seg_tab[(v / pow10(i)) % 10];
`ifdef SCORE_DISPLAY_BLANK_EN
            if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies a new score and counts edges until the done pulse is seen (-1 on timeout).
    task automatic convert(input int v, input int budget, output int lat, output logic busy1);
        logic seen;
        score = SCORE_W'(v);
        lat   = -1;
        seen  = 1'b0;
        busy1 = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            if (!seen) begin
                tick();
                if (i == 1) busy1 = busy;
                if (done) begin
                    lat  = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    vec_t vecs [10];
    int   lat;
    logic busy1;
    int   bad;
    int   last;
    int   v;
    int   first_bcd;

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        vecs[0] = '{7,    16'h0007};
        vecs[1] = '{1023, 16'h1023};
        vecs[2] = '{40,   16'h0040};
        vecs[3] = '{1003, 16'h1003};
        vecs[4] = '{999,  16'h0999};
        vecs[5] = '{100,  16'h0100};
        vecs[6] = '{9,    16'h0009};
        vecs[7] = '{10,   16'h0010};
        vecs[8] = '{512,  16'h0512};
        vecs[9] = '{0,    16'h0000};
        checks = 0;
        errors = 0;

        rst   = 1'b1;
        score = '0;
        tick();
        check("reset_bcd",  32'(bcd),  32'h0);
        check("reset_hex",  32'(hex),  32'(model_hex(0)));
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || done || bcd != 16'h0) bad++;
        end
        check("idle_zero_quiet", 32'(bad), 32'h0);
        check("idle_zero_hex", 32'(hex), 32'(model_hex(0)));

        foreach (vecs[i]) begin
            convert(vecs[i].value, 30, lat, busy1);
            check($sformatf("vec%0d_busy", i), 32'(busy1), 32'h1);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_hex", i), 32'(hex), 32'(model_hex(vecs[i].value)));
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'h0);
            tick();
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'h0);
            if (vecs[i].value == 1023) begin
                check("hex3_1023", 32'(hex[27:21]), 32'(7'b1111001));
                check("hex2_1023", 32'(hex[20:14]), 32'(7'b1000000));
                check("hex1_1023", 32'(hex[13:7]),  32'(7'b0100100));
                check("hex0_1023", 32'(hex[6:0]),   32'(7'b0110000));
            end
            if (vecs[i].value == 40) begin
`ifdef SCORE_DISPLAY_BLANK_EN
                check("hex3_40", 32'(hex[27:21]), 32'(7'b1111111));
                check("hex2_40", 32'(hex[20:14]), 32'(7'b1111111));
`else
                check("hex3_40", 32'(hex[27:21]), 32'(7'b1000000));
                check("hex2_40", 32'(hex[20:14]), 32'(7'b1000000));
`endif
                check("hex1_40", 32'(hex[13:7]), 32'(7'b0011001));
                check("hex0_40", 32'(hex[6:0]),  32'(7'b1000000));
            end
            if (vecs[i].value == 7)
                check("hex0_7", 32'(hex[6:0]), 32'(7'b1111000));
        end

        // 5 -> 6 -> 7 on consecutive cycles: 5 completes, then 7; 6 never displayed.
        score = 10'd5;
        tick();
        score = 10'd6;
        tick();
        score = 10'd7;
        lat = -1;
        first_bcd = -1;
        bad = 0;
        for (int i = 3; i <= 40; i++) begin
            if (lat < 0) begin
                tick();
                if (bcd == 16'h0006) bad++;
                if (done && first_bcd < 0) begin
                    first_bcd = int'(bcd);
                    check("chg_first_latency", 32'(i), 32'(LAT));
                end else if (done) begin
                    lat = i;
                end
            end
        end
        check("chg_first_bcd", 32'(first_bcd), 32'h0005);
        check("chg_second_latency", 32'(lat), 32'(2 * LAT));
        check("chg_second_bcd", 32'(bcd), 32'h0007);
        check("chg_no_six", 32'(bad), 32'h0);

        // Reset four cycles into a conversion of 999 discards it.
        score = 10'd999;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", 32'(busy), 32'h1);
        rst   = 1'b1;
        score = '0;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_bcd",  32'(bcd),  32'h0);
        check("abort_hex",  32'(hex),  32'(model_hex(0)));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) bad++;
        end
        check("abort_no_done", 32'(bad), 32'h0);

        // Randomized isolated conversions.
        last = 0;
        for (int n = 0; n < 20; n++) begin
            v = int'($urandom_range(0, 1023));
            if (v == last) v = (v + 1) % 1024;
            convert(v, 30, lat, busy1);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(LAT));
            check($sformatf("rnd%0d_bcd", n), 32'(bcd), 32'(model_bcd(v)));
            check($sformatf("rnd%0d_hex", n), 32'(hex), 32'(model_hex(v)));
            last = v;
        end

        // Random burst of changes; the final stable value must end up displayed.
        for (int n = 0; n < 30; n++) begin
            score = SCORE_W'($urandom_range(0, 1023));
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) tick();
        end
        v = int'(score);
        for (int i = 0; i < 60; i++) tick();
        check("burst_busy", 32'(busy), 32'h0);
        check("burst_bcd", 32'(bcd), 32'(model_bcd(v)));
        check("burst_hex", 32'(hex), 32'(model_hex(v)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
